// File: rtl/result_reporter.sv
// -----------------------------------------------------------------------------
// result_reporter
//   Buffers result pulses from work_handler in a small FIFO and sends each entry
//   to serial_tx as a framed byte packet:
//     SOF_BYTE, TYPE, data[31:24], data[23:16], data[15:8], data[7:0] [, CHK]
//   TYPE is TYPE_FOUND for a found nonce, TYPE_DONE for an exhausted range.
//
//   Optional feature macro: RESULT_CHECKSUM_EN
//     defined   -> 7-byte packet, last byte = XOR of TYPE and the four data bytes
//     undefined -> 6-byte packet, no checksum logic
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   new_result        1-cycle pulse: capture result_data / result_found
//   result_data[31:0] nonce for the result
//   result_found      1 = nonce found, 0 = range complete without a hit
//   new_work          1-cycle pulse: clears the sticky overflow flag
//   tx_data[7:0]      byte to serial_tx (holds its value between strobes)
//   new_tx_data       1-cycle strobe, tx_data valid
//   tx_busy           serial_tx busy
//   fifo_level        entries queued, not counting the packet in flight
//   overflow          sticky: a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module result_reporter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SOF_BYTE   = 8'hA5,
  parameter logic [7:0] TYPE_FOUND = 8'h01,
  parameter logic [7:0] TYPE_DONE  = 8'h02
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          new_result,
  input  logic [31:0]                   result_data,
  input  logic                          result_found,
  input  logic                          new_work,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

`ifdef RESULT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_HOLD = 3'd3,
    S_WAIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Packet in flight
  logic [32:0]   shadow_q, shadow_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          full, push, pop, drop, last_byte, advance;
  logic [7:0]    cur_byte, type_byte;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  assign last_byte = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (level_q != '0) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: if (!tx_busy) state_d = S_HOLD;
      // HOLD gives serial_tx a cycle to raise tx_busy after the strobe.
      S_HOLD: state_d = S_WAIT;
      S_WAIT: if (!tx_busy) state_d = last_byte ? S_IDLE : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // The strobe is combinational so the first byte leaves in the SEND cycle;
  // tx_data shows the new byte in that same cycle and then holds it.
  // ---------------------------------------------------------------------------
  always_comb begin
    new_tx_data = (state_q == S_SEND) && !tx_busy;
    pop         = (state_q == S_LOAD);
    advance     = (state_q == S_WAIT) && !tx_busy && !last_byte;
    tx_data     = new_tx_data ? cur_byte : tx_data_q;
  end

  // ---------------------------------------------------------------------------
  // Byte selection from the shadow entry
  // ---------------------------------------------------------------------------
  assign type_byte = shadow_q[32] ? TYPE_FOUND : TYPE_DONE;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0: cur_byte = SOF_BYTE;
      3'd1: cur_byte = type_byte;
      3'd2: cur_byte = shadow_q[31:24];
      3'd3: cur_byte = shadow_q[23:16];
      3'd4: cur_byte = shadow_q[15:8];
      3'd5: cur_byte = shadow_q[7:0];
`ifdef RESULT_CHECKSUM_EN
      3'd6: cur_byte = type_byte ^ shadow_q[31:24] ^ shadow_q[23:16]
                     ^ shadow_q[15:8] ^ shadow_q[7:0];
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO control. A full FIFO still accepts a push in the LOAD cycle because
  // the head leaves for the shadow register on the same edge.
  // ---------------------------------------------------------------------------
  assign full = (level_q == DEPTH_L);
  assign push = new_result && (!full || pop);
  assign drop = new_result && !push;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as new_work keeps the flag set.
    if (drop)          ovf_d = 1'b1;
    else if (new_work) ovf_d = 1'b0;

    if (pop) begin
      shadow_d = mem_q[rd_ptr_q];
      idx_d    = 3'd0;
    end else if (advance) begin
      idx_d = idx_q + 3'd1;
    end

    if (new_tx_data) tx_data_d = cur_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      shadow_q  <= '0;
      idx_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {result_found, result_data};
  end

  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_reporter.sv
`timescale 1ns/1ps
module tb_result_reporter;

  localparam int DEPTH = 4;
`ifdef RESULT_CHECKSUM_EN
  localparam int PKT_LEN = 7;
`else
  localparam int PKT_LEN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_result = 1'b0;
  logic [31:0] result_data = 32'h0;
  logic        result_found = 1'b0;
  logic        new_work = 1'b0;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  wire         tx_busy;
  logic [2:0]  fifo_level;
  logic        overflow;

  // serial_tx stand-in: auto mode stays busy 10 clocks per byte, else manual.
  logic auto_tx = 1'b1;
  logic man_busy = 1'b0;
  int   busy_cnt = 0;
  assign tx_busy = auto_tx ? (busy_cnt != 0) : man_busy;

  result_reporter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .new_result(new_result), .result_data(result_data),
    .result_found(result_found), .new_work(new_work), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed strobes
  logic [7:0] blog[$];
  int         slog[$];
  bit         strobe_seen = 0;
  bit         prev_str = 0;

  always begin
    @(posedge clk);
    #1;
    if (strobe_seen)       busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
  end

  // ---------------------------------------------------------------------------
  // Reference model: queue of entries, byte list of the packet in flight, and
  // the handshake phase of the sender.
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_LOAD, M_SEND, M_GUARD, M_RELEASE} ph_t;
  ph_t         ph = M_IDLE;
  logic [32:0] mq[$];
  logic [7:0]  pkt[$];
  logic [7:0]  m_last = 8'h00;
  bit          m_ovf = 0;
  bit          exp_str, m_pop, m_push;
  logic [7:0]  exp_byte, tb_type;
  logic [32:0] m_e;
  int          lvl0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete(); pkt.delete();
      ph = M_IDLE; m_last = 8'h00; m_ovf = 0;
      strobe_seen = 0; prev_str = 0;
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_strobe", new_tx_data, 1'b0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overflow", overflow, 1'b0);
    end else begin
      exp_str  = (ph == M_SEND) && !tx_busy;
      exp_byte = m_last;
      if (exp_str && pkt.size() > 0) exp_byte = pkt[0];
      chk("strobe", new_tx_data, exp_str);
      chk("tx_data", tx_data, exp_byte);
      chk("level", fifo_level, mq.size());
      chk("overflow", overflow, m_ovf);
      if (new_tx_data) begin
        chk("strobe_while_busy", tx_busy, 1'b0);
        chk("strobe_back_to_back", prev_str, 1'b0);
        blog.push_back(tx_data);
        slog.push_back(cyc);
      end
      prev_str    = new_tx_data;
      strobe_seen = new_tx_data;

      // advance the model across the coming edge
      lvl0   = mq.size();
      m_pop  = (ph == M_LOAD) && (lvl0 > 0);
      m_push = new_result && ((lvl0 < DEPTH) || m_pop);
      if (m_pop) begin
        m_e = mq.pop_front();
        tb_type = m_e[32] ? 8'h01 : 8'h02;
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(tb_type);
        for (int k = 3; k >= 0; k--) pkt.push_back(m_e[k*8 +: 8]);
`ifdef RESULT_CHECKSUM_EN
        pkt.push_back(tb_type ^ m_e[31:24] ^ m_e[23:16] ^ m_e[15:8] ^ m_e[7:0]);
`endif
      end
      if (m_push) mq.push_back({result_found, result_data});
      if (new_result && !m_push) m_ovf = 1;
      else if (new_work)         m_ovf = 0;
      case (ph)
        M_IDLE:    if (lvl0 > 0) ph = M_LOAD;
        M_LOAD:    ph = M_SEND;
        M_SEND:    if (!tx_busy) begin
                     if (pkt.size() > 0) m_last = pkt.pop_front();
                     ph = M_GUARD;
                   end
        M_GUARD:   ph = M_RELEASE;
        M_RELEASE: if (!tx_busy) ph = (pkt.size() == 0) ? M_IDLE : M_SEND;
        default:   ph = M_IDLE;
      endcase
    end
  end

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int i = 0;
    while (blog.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk(nm, (blog.size() >= n), 1'b1);
  endtask

  task automatic pulse(input logic [31:0] d, input logic f);
    new_result = 1'b1; result_data = d; result_found = f;
    tick();
    new_result = 1'b0;
  endtask

  logic [7:0] e1 [6];
  logic [7:0] e2 [6];
  logic [7:0] e3 [6];
  int base, n0;

  initial begin
    e1 = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    e2 = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF};
    e3 = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00};

    // reset
    repeat (2) tick();
    @(negedge clk);
    chk("t0_tx_data", tx_data, 8'h00);
    chk("t0_strobe", new_tx_data, 1'b0);
    chk("t0_level", fifo_level, 0);
    chk("t0_overflow", overflow, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: found result, SOF latency
    base = blog.size();
    n0 = cyc;
    pulse(32'hDEADBEEF, 1'b1);
    wait_bytes(base + PKT_LEN, 300, "t1_timeout");
    for (int k = 0; k < 6; k++)
      if (blog.size() > base + k) chk("t1_byte", blog[base + k], e1[k]);
    if (slog.size() > base) chk("t1_sof_cycle", slog[base], n0 + 3);
    repeat (15) tick();

    // 2: range-done result, level drains at LOAD
    base = blog.size();
    pulse(32'h0000FFFF, 1'b0);
    @(negedge clk);
    chk("t2_level_queued", fifo_level, 1);
    tick(); tick();
    @(negedge clk);
    chk("t2_level_after_load", fifo_level, 0);
    chk("t2_sof_strobe", new_tx_data, 1'b1);
    wait_bytes(base + PKT_LEN, 300, "t2_timeout");
    for (int k = 0; k < 6; k++)
      if (blog.size() > base + k) chk("t2_byte", blog[base + k], e2[k]);
    repeat (15) tick();

    // 3: fill while serial_tx is busy
    auto_tx = 1'b0; man_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      new_result = 1'b1; result_data = 32'h1000_0000 + i; result_found = (i % 2 == 1);
      tick();
    end
    new_result = 1'b0;
    @(negedge clk);
    chk("t3_level_full", fifo_level, 4);
    chk("t3_no_overflow", overflow, 1'b0);
    tick();
    pulse(32'h1000_0005, 1'b1);
    @(negedge clk);
    chk("t3_overflow_set", overflow, 1'b1);
    chk("t3_level_kept", fifo_level, 4);

    // 4: new_work clears; a simultaneous drop wins
    tick();
    new_work = 1'b1; tick(); new_work = 1'b0;
    @(negedge clk);
    chk("t4_cleared", overflow, 1'b0);
    tick();
    new_work = 1'b1;
    pulse(32'h1000_0006, 1'b0);
    new_work = 1'b0;
    @(negedge clk);
    chk("t4_set_wins", overflow, 1'b1);
    chk("t4_level", fifo_level, 4);
    tick();
    new_work = 1'b1; tick(); new_work = 1'b0;
    @(negedge clk);
    chk("t4_cleared_again", overflow, 1'b0);

    // 5: push into a full FIFO in the LOAD cycle
    tick();
    base = blog.size();
    man_busy = 1'b0;
    wait_bytes(base + PKT_LEN, 100, "t5_first_pkt_timeout");
    // last strobe S; now S+1 (HOLD), S+2 WAIT, S+3 IDLE, S+4 LOAD
    repeat (3) tick();
    pulse(32'hCAFE0001, 1'b1);
    @(negedge clk);
    chk("t5_level_unchanged", fifo_level, 4);
    chk("t5_no_overflow", overflow, 1'b0);
    for (int k = 0; k < 6; k++)
      if (blog.size() > base + k) chk("t5_first_byte", blog[base + k], e3[k]);
    wait_bytes(base + 6 * PKT_LEN, 400, "t5_drain_timeout");
    repeat (5) tick();
    @(negedge clk);
    chk("t5_drained", fifo_level, 0);
    if (blog.size() > base + 5 * PKT_LEN + 5)
      chk("t5_last_pkt_tail", blog[base + 5 * PKT_LEN + 5], 8'h01);

    // 6: reset mid-packet
    tick();
    auto_tx = 1'b1;
    pulse(32'h11223344, 1'b1);
    pulse(32'h55667788, 1'b0);
    base = blog.size();
    wait_bytes(base + 3, 200, "t6_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_tx_data", tx_data, 8'h00);
    chk("t6_strobe", new_tx_data, 1'b0);
    chk("t6_level", fifo_level, 0);
    chk("t6_overflow", overflow, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    base = blog.size();
    repeat (60) tick();
    chk("t6_no_strobes", blog.size(), base);
    chk("t6_level_after", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
